// File: rtl/change_dispenser.sv
// Coin change dispenser: accepts a rupee amount, pays it out with 10-rupee
// coins first and 5-rupee coins for the remainder, one hopper handshake per coin.
// Optional watchdog on the hopper acknowledge: define DISPENSE_TIMEOUT_EN.
module change_dispenser #(
    parameter int unsigned INV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_amount,
    input  logic             load_valid,
    input  logic [INV_W-1:0] load5,
    input  logic [INV_W-1:0] load10,
    output logic             eject5,
    output logic             eject10,
    input  logic             ack5,
    input  logic             ack10,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv10
);

    // Arithmetic width: wide enough for the 6-bit amount plus headroom and the inventory.
    localparam int unsigned CW = (INV_W > 7) ? INV_W : 7;

    typedef enum logic [2:0] {IDLE, CHECK, EJ10, GAP10, EJ5, GAP5, DONE, ERR} state_t;

    state_t          state;
    logic [5:0]      amount_q;
    logic [CW-1:0]   n10_q;
    logic [CW-1:0]   n5_q;

    logic [CW-1:0]   amt_w;
    logic [CW-1:0]   q10;
    logic [CW-1:0]   n10_calc;
    logic [CW-1:0]   rem;
    logic [CW-1:0]   n5_calc;
    logic            bad_amt;
    logic            short5;
    logic            timeout;

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
    endfunction

    assign req_ready = (state == IDLE);

    // Coin split for the latched amount, using as many 10s as the inventory allows.
    always_comb begin
        amt_w    = CW'(amount_q);
        q10      = amt_w / CW'(10);
        n10_calc = (q10 < CW'(inv10)) ? q10 : CW'(inv10);
        rem      = amt_w - (n10_calc * CW'(10));
        n5_calc  = rem / CW'(5);
        bad_amt  = (amt_w % CW'(5)) != '0;
        short5   = n5_calc > CW'(inv5);
    end

`ifdef DISPENSE_TIMEOUT_EN
    logic [7:0] wdog_q;

    // Watchdog: zero outside the eject states, so it starts at 0 on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 8'd0;
        end else if ((state == EJ10) || (state == EJ5)) begin
            wdog_q <= wdog_q + 8'd1;
        end else begin
            wdog_q <= 8'd0;
        end
    end

    // 255th cycle in an eject state with no acknowledge.
    assign timeout = (wdog_q == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    // Main FSM with registered hopper commands, status pulses and inventory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            amount_q <= 6'd0;
            n10_q    <= '0;
            n5_q     <= '0;
            inv5     <= '0;
            inv10    <= '0;
            eject5   <= 1'b0;
            eject10  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        inv5  <= sat_add(inv5, load5);
                        inv10 <= sat_add(inv10, load10);
                    end
                    if (req_valid) begin
                        amount_q <= req_amount;
                        err_code <= 2'b00;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_amt) begin
                        err_code <= 2'b01;
                        err      <= 1'b1;
                        state    <= ERR;
                    end else if (short5) begin
                        err_code <= 2'b10;
                        err      <= 1'b1;
                        state    <= ERR;
                    end else begin
                        n10_q <= n10_calc;
                        n5_q  <= n5_calc;
                        if (n10_calc != '0) begin
                            eject10 <= 1'b1;
                            state   <= EJ10;
                        end else if (n5_calc != '0) begin
                            eject5 <= 1'b1;
                            state  <= EJ5;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                EJ10: begin
                    if (ack10) begin
                        eject10 <= 1'b0;
                        inv10   <= inv10 - INV_W'(1);
                        n10_q   <= n10_q - CW'(1);
                        state   <= GAP10;
                    end else if (timeout) begin
                        eject10  <= 1'b0;
                        err_code <= 2'b11;
                        err      <= 1'b1;
                        state    <= ERR;
                    end
                end
                GAP10: begin
                    if (n10_q != '0) begin
                        eject10 <= 1'b1;
                        state   <= EJ10;
                    end else if (n5_q != '0) begin
                        eject5 <= 1'b1;
                        state  <= EJ5;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                EJ5: begin
                    if (ack5) begin
                        eject5 <= 1'b0;
                        inv5   <= inv5 - INV_W'(1);
                        n5_q   <= n5_q - CW'(1);
                        state  <= GAP5;
                    end else if (timeout) begin
                        eject5   <= 1'b0;
                        err_code <= 2'b11;
                        err      <= 1'b1;
                        state    <= ERR;
                    end
                end
                GAP5: begin
                    if (n5_q != '0) begin
                        eject5 <= 1'b1;
                        state  <= EJ5;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
